// File: rtl/simplest_pkg.sv
// Shared definitions for the 1-bit "simplest" accumulator cores: opcodes,
// ROM geometry and the ALU / ROM-read helper functions.
package simplest_pkg;

    localparam int PC_W      = 3;
    localparam int ROM_DEPTH = 8;
    localparam int WORD_W    = 3;
    localparam int PROG_W    = WORD_W * ROM_DEPTH;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_AND  = 2'b01,
        OP_OR   = 2'b10,
        OP_XOR  = 2'b11
    } op_e;

    function automatic logic [WORD_W-1:0] rom_word(input logic [PROG_W-1:0] prog,
                                                   input logic [PC_W-1:0]   pc);
        return prog[WORD_W*int'(pc) +: WORD_W];
    endfunction

    // Word layout is {op[1:0], d}; the result is the next accumulator value.
    function automatic logic alu(input logic [WORD_W-1:0] word, input logic acc);
        logic result;
        case (op_e'(word[2:1]))
            OP_LOAD: result = word[0];
            OP_AND:  result = acc & word[0];
            OP_OR:   result = acc | word[0];
            OP_XOR:  result = acc ^ word[0];
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/simplest_core.sv
// One 1-bit accumulator core with a parameter-defined 8-word ROM.
// Optional pc output when SIMPLEST4_PARA_PC_OUT_EN is defined.
module simplest_core
    import simplest_pkg::*;
#(
    parameter logic [PROG_W-1:0] PROG = 24'hFFFFF8
) (
    input  logic            clk,
    input  logic            preset,
    input  logic            counter_ram8_reset,
    output logic            acc_out
`ifdef SIMPLEST4_PARA_PC_OUT_EN
    ,
    output logic [PC_W-1:0] pc_out
`endif
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            acc_q;
    logic            acc_d;

    // Next-state: a PC-only reset rewinds without executing; otherwise execute and advance.
    always_comb begin
        pc_d  = pc_q;
        acc_d = acc_q;
        if (counter_ram8_reset) begin
            pc_d  = {PC_W{1'b0}};
            acc_d = acc_q;
        end else begin
            pc_d  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            acc_d = alu(rom_word(PROG, pc_q), acc_q);
        end
    end

    // State registers; preset overrides everything else.
    always_ff @(posedge clk) begin
        if (preset) begin
            pc_q  <= {PC_W{1'b0}};
            acc_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;
`ifdef SIMPLEST4_PARA_PC_OUT_EN
    assign pc_out  = pc_q;
`endif

endmodule

// File: rtl/simplest4_para.sv
// Four independent simplest_core instances in lockstep on one clock.
// Optional pc_out0..pc_out3 ports when SIMPLEST4_PARA_PC_OUT_EN is defined.
module simplest4_para
    import simplest_pkg::*;
#(
    parameter logic [PROG_W-1:0] PROG0 = 24'hFFFFF8,
    parameter logic [PROG_W-1:0] PROG1 = 24'hFFFFF8,
    parameter logic [PROG_W-1:0] PROG2 = 24'hFFFFF8,
    parameter logic [PROG_W-1:0] PROG3 = 24'hFFFFF8
) (
    input  logic            clk,
    input  logic            preset,
    input  logic            counter_ram8_reset,
    output logic            accumulator_output0,
    output logic            accumulator_output1,
    output logic            accumulator_output2,
    output logic            accumulator_output3
`ifdef SIMPLEST4_PARA_PC_OUT_EN
    ,
    output logic [PC_W-1:0] pc_out0,
    output logic [PC_W-1:0] pc_out1,
    output logic [PC_W-1:0] pc_out2,
    output logic [PC_W-1:0] pc_out3
`endif
);

    simplest_core #(.PROG(PROG0)) u_core0 (
        .clk                (clk),
        .preset             (preset),
        .counter_ram8_reset (counter_ram8_reset),
        .acc_out            (accumulator_output0)
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        ,
        .pc_out             (pc_out0)
`endif
    );

    simplest_core #(.PROG(PROG1)) u_core1 (
        .clk                (clk),
        .preset             (preset),
        .counter_ram8_reset (counter_ram8_reset),
        .acc_out            (accumulator_output1)
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        ,
        .pc_out             (pc_out1)
`endif
    );

    simplest_core #(.PROG(PROG2)) u_core2 (
        .clk                (clk),
        .preset             (preset),
        .counter_ram8_reset (counter_ram8_reset),
        .acc_out            (accumulator_output2)
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        ,
        .pc_out             (pc_out2)
`endif
    );

    simplest_core #(.PROG(PROG3)) u_core3 (
        .clk                (clk),
        .preset             (preset),
        .counter_ram8_reset (counter_ram8_reset),
        .acc_out            (accumulator_output3)
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        ,
        .pc_out             (pc_out3)
`endif
    );

endmodule

// File: tb/tb_simplest4_para.sv
// Directed bench for simplest4_para. Core0 runs LOAD1,AND0,XOR1..; core1 runs
// LOAD0,OR1,OR1,OR1,OR1,XOR1..; cores 2 and 3 run the default toggle program.
module tb_simplest4_para;

    logic clk;
    logic preset;
    logic counter_ram8_reset;
    logic out0, out1, out2, out3;
`ifdef SIMPLEST4_PARA_PC_OUT_EN
    logic [2:0] pc0, pc1, pc2, pc3;
`endif

    int total = 0;
    int bad   = 0;

    simplest4_para #(
        .PROG0(24'hFFFFD1),
        .PROG1(24'hFFDB68)
    ) dut (
        .clk                 (clk),
        .preset              (preset),
        .counter_ram8_reset  (counter_ram8_reset),
        .accumulator_output0 (out0),
        .accumulator_output1 (out1),
        .accumulator_output2 (out2),
        .accumulator_output3 (out3)
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        ,
        .pc_out0             (pc0),
        .pc_out1             (pc1),
        .pc_out2             (pc2),
        .pc_out3             (pc3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_preset();
        preset = 1'b1;
        counter_ram8_reset = 1'b0;
        step(1);
        preset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] acc;
        preset = 1'b1;
        counter_ram8_reset = 1'b0;
        step(2);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0000) begin
            bad++;
            $display("FAIL reset_acc: got %b want %b", acc, 4'b0000);
        end
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        total++;
        if ({pc3, pc2, pc1, pc0} !== 12'h000) begin
            bad++;
            $display("FAIL reset_pc: got %h want %h", {pc3, pc2, pc1, pc0}, 12'h000);
        end
`endif
        preset = 1'b0;
    endtask

    // Default program on cores 2/3: 0,1,0,1,0 after edges 1..5.
    task automatic test_default();
        logic [1:0] exp_tab [5];
        logic [1:0] got;
        exp_tab = '{2'b00, 2'b11, 2'b00, 2'b11, 2'b00};
        do_preset();
        for (int e = 0; e < 5; e++) begin
            step(1);
            got = {out3, out2};
            total++;
            if (got !== exp_tab[e]) begin
                bad++;
                $display("FAIL default_edge%0d: got %b want %b", e + 1, got, exp_tab[e]);
            end
        end
    endtask

    task automatic test_prog();
        logic [1:0] got;
        do_preset();
        step(1);
        got = {out1, out0};
        total++;
        if (got !== 2'b01) begin
            bad++;
            $display("FAIL prog_edge1: got %b want %b", got, 2'b01);
        end
        step(1);
        got = {out1, out0};
        total++;
        if (got !== 2'b10) begin
            bad++;
            $display("FAIL prog_edge2: got %b want %b", got, 2'b10);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] acc;
        do_preset();
        step(8);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b1100) begin
            bad++;
            $display("FAIL wrap_edge8: got %b want %b", acc, 4'b1100);
        end
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        total++;
        if ({pc3, pc2, pc1, pc0} !== 12'h000) begin
            bad++;
            $display("FAIL wrap_pc: got %h want %h", {pc3, pc2, pc1, pc0}, 12'h000);
        end
`endif
        step(1);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_edge9: got %b want %b", acc, 4'b0001);
        end
        step(1);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b1110) begin
            bad++;
            $display("FAIL wrap_edge10: got %b want %b", acc, 4'b1110);
        end
    endtask

    // PC-only reset at pc=5; core1 holds acc=1 there.
    task automatic test_pc_reset();
        logic [3:0] acc;
        do_preset();
        step(5);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0011) begin
            bad++;
            $display("FAIL pcrst_before: got %b want %b", acc, 4'b0011);
        end
        counter_ram8_reset = 1'b1;
        step(1);
        counter_ram8_reset = 1'b0;
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0011) begin
            bad++;
            $display("FAIL pcrst_hold: got %b want %b", acc, 4'b0011);
        end
`ifdef SIMPLEST4_PARA_PC_OUT_EN
        total++;
        if ({pc3, pc2, pc1, pc0} !== 12'h000) begin
            bad++;
            $display("FAIL pcrst_pc: got %h want %h", {pc3, pc2, pc1, pc0}, 12'h000);
        end
`endif
        step(1);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0001) begin
            bad++;
            $display("FAIL pcrst_after: got %b want %b", acc, 4'b0001);
        end
    endtask

    task automatic test_both();
        logic [3:0] acc;
        do_preset();
        step(2);
        preset = 1'b1;
        counter_ram8_reset = 1'b1;
        step(1);
        preset = 1'b0;
        counter_ram8_reset = 1'b0;
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0000) begin
            bad++;
            $display("FAIL both_acc: got %b want %b", acc, 4'b0000);
        end
        step(1);
        acc = {out3, out2, out1, out0};
        total++;
        if (acc !== 4'b0001) begin
            bad++;
            $display("FAIL both_after: got %b want %b", acc, 4'b0001);
        end
    endtask

    initial begin
        preset = 1'b1;
        counter_ram8_reset = 1'b0;
        test_reset();
        test_default();
        test_prog();
        test_wrap();
        test_pc_reset();
        test_both();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simplest4_para.md
Name: simplest4_para

Overview:
Four independent 1-bit accumulator cores ("simplest" CPUs) run in lockstep on one clock.
- Each core has a hard-wired 8-word program ROM (ram8), a 3-bit program counter and a 1-bit accumulator.
- Each core executes one instruction per clock edge.
- Top-level parallel wrapper; each accumulator bit is brought out for observation.

Parameters:
- PROG0, default 24'hFFFFF8, core 0 program: word i at bits [3i+2:3i].
- PROG1, default 24'hFFFFF8, core 1 program, same packing.
- PROG2, default 24'hFFFFF8, core 2 program, same packing.
- PROG3, default 24'hFFFFF8, core 3 program, same packing.
- Default program: word0 = LOAD 0, words 1..7 = XOR 1, so the accumulator toggles.

Ports:
- clk  input  1  single system clock, rising edge.
- preset  input  1  reset: synchronous, active-high; clears all PCs and accumulators.
- counter_ram8_reset  input  1  synchronous active-high; clears all PCs only.
- accumulator_output0  output  1  core 0 accumulator.
- accumulator_output1  output  1  core 1 accumulator.
- accumulator_output2  output  1  core 2 accumulator.
- accumulator_output3  output  1  core 3 accumulator.

Behaviour:
- Instruction word, 3 bits: op[2:1], d[0].
  - 00 LOAD: acc <= d.
  - 01 AND: acc <= acc & d.
  - 10 OR: acc <= acc | d.
  - 11 XOR: acc <= acc ^ d.
- Per rising clk edge, in priority order:
  - preset=1: pc <= 0, acc <= 0 in every core.
  - else counter_ram8_reset=1: pc <= 0; acc holds; no instruction executes.
  - else: acc <= f(acc, ROM[pc]); pc <= pc+1.
- PC wraps 7 -> 0 with no stall.
- Latency: the instruction at pc is visible on accumulator_outputN one edge later.
- Outputs are registered directly from acc; no combinational path from inputs.
- Reset values: all accumulator_outputN = 0, all pc = 0.
- No state is defined before the first preset; the bench must apply preset across at least one rising edge.
- ROMs are read-only: contents come from parameters, with no write port.
- The four cores share clk, preset and counter_ram8_reset and never interact, so every core is always at the same pc.
- Reset mid-operation: takes effect at the next edge and discards that edge's instruction.

Optional Feature:
- Macro SIMPLEST4_PARA_PC_OUT_EN.
- Defined: adds output ports pc_out0..pc_out3, each 3 bits, driven by each core's registered pc, 0 after reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package simplest_pkg holds:
  - opcode constants OP_LOAD=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11;
  - PC width 3, ROM depth 8;
  - word width 3.
- One sub-module, simplest_core: PROG parameter, clk/preset/counter_ram8_reset in, acc out, optional pc out.
- Top instantiates simplest_core four times with PROG0..PROG3.

Test Plan:
1. preset=1 for one edge with the default program -> all four outputs 0; under PC_OUT_EN all pc_out = 0.
2. Release preset, default program -> outputs after edges 1..5 are 0,1,0,1,0 on all cores.
3. PROG0 word0=LOAD1 (001), word1=AND0 (010); PROG1 word0=LOAD0, word1=OR1 (101) -> after edge1 out0=1, out1=0; after edge2 out0=0, out1=1.
4. Wrap, default program, 8 edges after reset -> pc back to 0; 9th edge executes LOAD 0 -> outputs 0; 10th edge -> 1.
5. counter_ram8_reset=1 for one edge at pc=5 with acc=1 -> acc stays 1, pc=0; next edge executes word0, LOAD 0 -> 0.
6. preset and counter_ram8_reset both high with acc=1 -> acc=0, pc=0, so preset wins.
